cpu_mem_io: RTL

//  Memory/I-O slave directly downstream of the cpu. Consumes addr_bus, c_ri, c_ro, mem_clk and mem_io,
//  and exchanges data on split bus lanes; top level ties bus_out/bus_oe onto the tri-state bus.

---
 rtl/cpu_mem_io_if.sv | 33 +++
 rtl/cpu_mem_io.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cpu_mem_io_if.sv
// cpu_mem_io_if: signal bundle between the cpu side (plus the OUT sink and the IN source)
// and the cpu_mem_io slave.
//   cpu bus : addr, c_ri, c_ro, mem_clk, mem_io, bus_in -> slave; bus_out, bus_oe <- slave
//   OUT     : out_data, out_valid, out_ovf <- slave; out_ready -> slave
//   IN      : in_data, in_valid -> slave; in_ready <- slave
// Modports: slave (the memory/IO block), master (cpu/bench side).
interface cpu_mem_io_if;
  logic [7:0] addr;
  logic       c_ri;
  logic       c_ro;
  logic       mem_clk;
  logic       mem_io;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_ovf;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport slave (
    input  addr, c_ri, c_ro, mem_clk, mem_io, bus_in, out_ready, in_data, in_valid,
    output bus_out, bus_oe, out_data, out_valid, out_ovf, in_ready
  );

  modport master (
    output addr, c_ri, c_ro, mem_clk, mem_io, bus_in, out_ready, in_data, in_valid,
    input  bus_out, bus_oe, out_data, out_valid, out_ovf, in_ready
  );
endinterface

// File: rtl/cpu_mem_io.sv
// cpu_mem_io: memory/I-O slave behind the cpu.
//   - RAM_WORDS x 8 RAM (not cleared by reset), combinational read, write on strobe.
//   - OUT_DEPTH-entry output FIFO fed by OUT pushes, drained by a valid/ready sink.
//   - Single-byte input holding register filled by a valid/ready source, consumed by IN reads.
// Ports:
//   clk, reset_n  : system clock, asynchronous active-low reset
//   io            : cpu_mem_io_if.slave (cpu bus, OUT stream, IN stream)
//   ld_we/ld_addr/ld_data : RAM loader port, present only when MEMIO_LOADER_EN is defined.
//                   Loader writes work even in reset and win over a same-clk cpu RAM write.
// Configuration macro: MEMIO_LOADER_EN
module cpu_mem_io #(
  parameter int OUT_DEPTH = 4,
  parameter int RAM_WORDS = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  cpu_mem_io_if.slave     io
`ifdef MEMIO_LOADER_EN
  ,
  input  logic            ld_we,
  input  logic [7:0]      ld_addr,
  input  logic [7:0]      ld_data
`endif
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(OUT_DEPTH);

  logic       stb;
  assign stb = io.mem_clk & reset_n;

  // ---------------- RAM ----------------
  logic [7:0] ram [RAM_WORDS];
  logic       cpu_wr;
  assign cpu_wr = stb & io.c_ri & ~io.mem_io;

  // No reset: contents persist across reset_n.
  always_ff @(posedge clk) begin
`ifdef MEMIO_LOADER_EN
    if (ld_we)
      ram[ld_addr[AW-1:0]] <= ld_data;
    else if (cpu_wr)
      ram[io.addr[AW-1:0]] <= io.bus_in;
`else
    if (cpu_wr)
      ram[io.addr[AW-1:0]] <= io.bus_in;
`endif
  end

  // ---------------- output FIFO ----------------
  logic [7:0]    fifo_mem [OUT_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, push_req, push_ok, pop, ovf;

  assign full     = (count == FULL_CNT);
  assign push_req = stb & io.c_ri & io.mem_io;
  assign pop      = io.out_valid & io.out_ready;
  // A pop in the same clk frees the slot, so a push while full is still accepted.
  assign push_ok  = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= io.bus_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req & full & ~pop) ovf <= 1'b1;
    end
  end

  assign io.out_valid = (count != '0);
  // Storage is not reset; mask it so an empty FIFO always shows 0.
  assign io.out_data  = io.out_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign io.out_ovf   = ovf;

  // ---------------- input holding register ----------------
  logic       hold_full;
  logic [7:0] hold_reg;
  logic       capture, consume;

  assign capture = io.in_valid & ~hold_full;
  assign consume = stb & io.c_ro & io.mem_io & hold_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_reg  <= 8'h00;
    end else begin
      // capture needs empty, consume needs full: never both in one clk
      if (capture) begin
        hold_full <= 1'b1;
        hold_reg  <= io.in_data;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign io.in_ready = ~hold_full;

  // ---------------- read path ----------------
  logic [7:0] hold_byte;
  assign hold_byte  = hold_full ? hold_reg : 8'h00;
  // Held quiet while in reset so the shared bus is released.
  assign io.bus_oe  = io.c_ro & reset_n;
  assign io.bus_out = !reset_n  ? 8'h00 :
                      io.mem_io ? hold_byte : ram[io.addr[AW-1:0]];

endmodule
